// File: rtl/burst_ram_arbiter.sv
// rtl/burst_ram_arbiter.sv - two-client round-robin arbiter in front of a single BurstRAM port
`timescale 1ns/1ps
module burst_ram_arbiter #(
    parameter int DATA_BITWIDTH  = 64,
    parameter int DEPTH_BITWIDTH = 8,
    parameter int BURST_COUNT    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          c0_cmd,
    input  logic                          c0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]     c0_addr,
    input  logic [DATA_BITWIDTH-1:0]      c0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    c0_data_mask,
    output logic [DATA_BITWIDTH-1:0]      c0_rd_data,
    output logic                          c0_rd_data_valid,
    output logic                          c0_busy,
    input  logic                          c1_cmd,
    input  logic                          c1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]     c1_addr,
    input  logic [DATA_BITWIDTH-1:0]      c1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    c1_data_mask,
    output logic [DATA_BITWIDTH-1:0]      c1_rd_data,
    output logic                          c1_rd_data_valid,
    output logic                          c1_busy,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]     br_addr,
    output logic [DATA_BITWIDTH-1:0]      br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]    br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]      br_rd_data,
    input  logic                          br_rd_data_valid,
    input  logic                          br_busy
);
    localparam int MW = DATA_BITWIDTH / 8;
    localparam int CW = $clog2(BURST_COUNT);
    localparam logic [CW-1:0] LAST = CW'(BURST_COUNT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WRITE, READ, RELEASE} state_e;

    logic [1:0]                in_cmd, in_en;
    logic [DEPTH_BITWIDTH-1:0] in_addr  [2];
    logic [DATA_BITWIDTH-1:0]  in_wdata [2];
    logic [MW-1:0]             in_mask  [2];

    assign in_cmd      = {c1_cmd, c0_cmd};
    assign in_en       = {c1_cmd_en, c0_cmd_en};
    assign in_addr[0]  = c0_addr;
    assign in_addr[1]  = c1_addr;
    assign in_wdata[0] = c0_wr_data;
    assign in_wdata[1] = c1_wr_data;
    assign in_mask[0]  = c0_data_mask;
    assign in_mask[1]  = c1_data_mask;

    logic [1:0]                cmd_q, pend_q, busy_q, cap_q;
    logic [DEPTH_BITWIDTH-1:0] addr_q [2];
    logic [MW-1:0]             mask_q [2];
    logic [DATA_BITWIDTH-1:0]  beat_q [2][BURST_COUNT];
    logic [CW-1:0]             wcnt_q [2];

    state_e        state_q, state_d;
    logic          owner_q, owner_d, prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Capture slots: busy holds the client off from its own strobe until its transaction is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q  <= '0;
            pend_q <= '0;
            busy_q <= '0;
            cap_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
                wcnt_q[i] <= '0;
                for (int b = 0; b < BURST_COUNT; b++) beat_q[i][b] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (in_en[i] && !busy_q[i]) begin
                    busy_q[i]    <= 1'b1;
                    cmd_q[i]     <= in_cmd[i];
                    addr_q[i]    <= in_addr[i];
                    mask_q[i]    <= in_mask[i];
                    beat_q[i][0] <= in_wdata[i];
                    wcnt_q[i]    <= CW'(1);
                    cap_q[i]     <= in_cmd[i];
                    pend_q[i]    <= !in_cmd[i];
                end else if (cap_q[i]) begin
                    beat_q[i][wcnt_q[i]] <= in_wdata[i];
                    wcnt_q[i]            <= wcnt_q[i] + CW'(1);
                    if (wcnt_q[i] == LAST) begin
                        cap_q[i]  <= 1'b0;
                        pend_q[i] <= 1'b1;
                    end
                end else if (state_q == RELEASE && owner_q == 1'(i)) begin
                    pend_q[i] <= 1'b0;
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!br_busy && (|pend_q)) begin
                    owner_d = (&pend_q) ? prio_q : pend_q[1];
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Beat 0 of a write goes out with the command, so WRITE starts at beat 1.
                state_d = cmd_q[owner_q] ? WRITE : READ;
                cnt_d   = cmd_q[owner_q] ? CW'(1) : '0;
            end
            WRITE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = RELEASE;
            end
            READ: begin
                if (br_rd_data_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = RELEASE;
                end
            end
            RELEASE: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign br_cmd_en    = (state_q == ISSUE);
    assign br_cmd       = br_cmd_en & cmd_q[owner_q];
    assign br_addr      = br_cmd_en ? addr_q[owner_q] : '0;
    assign br_data_mask = br_cmd_en ? mask_q[owner_q] : '0;

    always_comb begin
        br_wr_data = '0;
        if (state_q == ISSUE && cmd_q[owner_q]) br_wr_data = beat_q[owner_q][0];
        else if (state_q == WRITE)              br_wr_data = beat_q[owner_q][cnt_q];
    end

    assign c0_rd_data       = br_rd_data;
    assign c1_rd_data       = br_rd_data;
    assign c0_rd_data_valid = br_rd_data_valid & (state_q == READ) & ~owner_q;
    assign c1_rd_data_valid = br_rd_data_valid & (state_q == READ) & owner_q;
    assign c0_busy          = busy_q[0];
    assign c1_busy          = busy_q[1];
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb/tb_burst_ram_arbiter.sv - directed and randomized checks of burst_ram_arbiter against a memory-level model
`timescale 1ns/1ps
module tb_burst_ram_arbiter;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam int BC = 4;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          t_cmd [2];
    logic          t_en  [2];
    logic [AW-1:0] t_addr[2];
    logic [DW-1:0] t_wdata[2];
    logic [MW-1:0] t_mask[2];

    logic [DW-1:0] c0_rd_data, c1_rd_data, br_wr_data, br_rd_data;
    logic          c0_rd_data_valid, c1_rd_data_valid, c0_busy, c1_busy;
    logic          br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
    logic [AW-1:0] br_addr;
    logic [MW-1:0] br_data_mask;
    logic [1:0]    busy;
    assign busy = {c1_busy, c0_busy};

    burst_ram_arbiter #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst(rst),
        .c0_cmd(t_cmd[0]), .c0_cmd_en(t_en[0]), .c0_addr(t_addr[0]), .c0_wr_data(t_wdata[0]),
        .c0_data_mask(t_mask[0]), .c0_rd_data(c0_rd_data), .c0_rd_data_valid(c0_rd_data_valid), .c0_busy(c0_busy),
        .c1_cmd(t_cmd[1]), .c1_cmd_en(t_en[1]), .c1_addr(t_addr[1]), .c1_wr_data(t_wdata[1]),
        .c1_data_mask(t_mask[1]), .c1_rd_data(c1_rd_data), .c1_rd_data_valid(c1_rd_data_valid), .c1_busy(c1_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    // Behavioural BurstRAM: variable read latency with gaps, optional random busy.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] ram_data;
    logic          ram_valid, ram_busy, stray, busy_rand;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_mask;
    int            rd_left, wr_left, lat;
    assign br_rd_data       = ram_data;
    assign br_rd_data_valid = ram_valid | stray;
    assign br_busy          = ram_busy;

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_valid <= 1'b0;
            ram_data  <= '0;
            ram_busy  <= 1'b0;
            rd_left = 0;
            wr_left = 0;
            lat     = 0;
        end else begin
            ram_valid <= 1'b0;
            ram_data  <= '0;
            if (wr_left > 0) begin
                mem[ram_addr] = merge(mem[ram_addr], br_wr_data, ram_mask);
                ram_addr = ram_addr + 8'd1;
                wr_left--;
            end else if (rd_left > 0) begin
                if (lat > 0) lat--;
                else if ($urandom_range(0, 3) != 0) begin
                    ram_valid <= 1'b1;
                    ram_data  <= mem[ram_addr];
                    ram_addr = ram_addr + 8'd1;
                    rd_left--;
                end
            end
            if (br_cmd_en) begin
                ram_mask = br_data_mask;
                if (br_cmd) begin
                    mem[br_addr] = merge(mem[br_addr], br_wr_data, br_data_mask);
                    ram_addr = br_addr + 8'd1;
                    wr_left  = BC - 1;
                end else begin
                    ram_addr = br_addr;
                    rd_left  = BC;
                    lat      = $urandom_range(0, 2);
                end
            end
            ram_busy <= (rd_left > 0) || (wr_left > 0) || (busy_rand && $urandom_range(0, 5) == 0);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] rd_q0[$], rd_q1[$], exp_q0[$], exp_q1[$], wlog[$];
    logic [AW-1:0] alog[$];
    logic          clog[$];
    logic [MW-1:0] mlog[$];
    int            tlog[$];
    int            wmon = 0, last_beat0 = 0, fall0 = -100;
    logic          busy0_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (c0_rd_data_valid) begin
                rd_q0.push_back(c0_rd_data);
                last_beat0 = cyc;
            end
            if (c1_rd_data_valid) rd_q1.push_back(c1_rd_data);
            if (wmon > 0) begin
                wlog.push_back(br_wr_data);
                wmon--;
            end
            if (br_cmd_en) begin
                alog.push_back(br_addr);
                clog.push_back(br_cmd);
                mlog.push_back(br_data_mask);
                tlog.push_back(cyc);
                if (br_cmd) begin
                    wlog.push_back(br_wr_data);
                    wmon = BC - 1;
                end
            end
            if (busy0_prev && !c0_busy) fall0 = cyc;
            busy0_prev = c0_busy;
        end
    end

    int total = 0, bad = 0;
    int acc, errs, n, t0;
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] wv [BC];
    logic [DW-1:0] wbuf [2][BC];
    int            wleft [2];

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(int c, logic en, logic cmd, logic [AW-1:0] ad, logic [MW-1:0] mk, logic [DW-1:0] d);
        t_en[c]    = en;
        t_cmd[c]   = cmd;
        t_addr[c]  = ad;
        t_mask[c]  = mk;
        t_wdata[c] = d;
    endtask

    task automatic clear_logs();
        rd_q0.delete(); rd_q1.delete(); wlog.delete();
        alog.delete(); clog.delete(); mlog.delete(); tlog.delete();
    endtask

    function automatic int alog_at(int i);
        return (i < alog.size()) ? int'(alog[i]) : -1;
    endfunction

    task automatic drain();
        int k = 0;
        while ((busy != 2'b00 || ram_busy || rd_left > 0 || wr_left > 0) && k < 300) begin
            tick();
            k++;
        end
        chk("drain_bound", DW'(k < 300), DW'(1));
        repeat (3) tick();
    endtask

    task automatic chk_rd(int c, logic [AW-1:0] ad);
        logic [DW-1:0] q[$];
        if (c == 0) q = rd_q0;
        else q = rd_q1;
        chk($sformatf("rd%0d_count@%0d", c, ad), DW'(q.size()), DW'(BC));
        for (int k = 0; k < BC && k < q.size(); k++)
            chk($sformatf("rd%0d_beat%0d@%0d", c, k, ad), q[k], ref_mem[ad + AW'(k)]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_c(0, 0, 0, '0, '0, '0);
        set_c(1, 0, 0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        stray = 1'b0;
        busy_rand = 1'b0;
        set_c(0, 0, 0, '0, '0, '0);
        set_c(1, 0, 0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy", DW'(busy), '0);
        chk("rst_br_cmd_en", DW'(br_cmd_en), '0);
        chk("rst_br_addr", DW'(br_addr), '0);
        chk("rst_br_wr_data", br_wr_data, '0);
        chk("rst_rd_valid", DW'({c1_rd_data_valid, c0_rd_data_valid}), '0);
        rst = 1'b0;
        tick();
        chk("idle_busy", DW'(busy), '0);
        chk("idle_br_cmd_en", DW'(br_cmd_en), '0);
        stray = 1'b1;
        #1;
        chk("stray_valid_dropped", DW'({c1_rd_data_valid, c0_rd_data_valid}), '0);
        tick();
        stray = 1'b0;
        repeat (2) tick();

        // Single read, client 0, addr 4
        clear_logs();
        set_c(0, 1, 0, 8'd4, '1, '0);
        t0 = cyc;
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        drain();
        chk("t1_ncmd", DW'(alog.size()), DW'(1));
        chk("t1_issue_cycle", DW'((tlog.size() > 0) ? tlog[0] : -1), DW'(t0 + 2));
        chk("t1_addr", DW'(alog_at(0)), DW'(4));
        chk_rd(0, 8'd4);
        chk("t1_c1_beats", DW'(rd_q1.size()), '0);
        chk("t1_busy_fall", DW'(fall0 - last_beat0), DW'(2));

        // Simultaneous reads after reset, then round-robin
        do_reset();
        clear_logs();
        set_c(0, 1, 0, 8'd8, '1, '0);
        set_c(1, 1, 0, 8'd16, '1, '0);
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        set_c(1, 0, 0, '0, '0, '0);
        drain();
        chk("t2_first", DW'(alog_at(0)), DW'(8));
        chk("t2_second", DW'(alog_at(1)), DW'(16));
        chk_rd(0, 8'd8);
        chk_rd(1, 8'd16);
        clear_logs();
        set_c(0, 1, 0, 8'd20, '1, '0);
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        drain();
        chk_rd(0, 8'd20);
        clear_logs();
        set_c(0, 1, 0, 8'd24, '1, '0);
        set_c(1, 1, 0, 8'd28, '1, '0);
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        set_c(1, 0, 0, '0, '0, '0);
        drain();
        chk("t2_rr_first", DW'(alog_at(0)), DW'(28));
        chk("t2_rr_second", DW'(alog_at(1)), DW'(24));
        chk_rd(1, 8'd28);
        chk_rd(0, 8'd24);

        // c1 write buffered behind a c0 read, then read back
        clear_logs();
        set_c(0, 1, 0, 8'd40, '1, '0);
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        tick();
        for (int k = 0; k < BC; k++) begin
            wv[k] = {16{4'(k + 1)}};
            set_c(1, k == 0, 1, 8'd32, 8'hFF, wv[k]);
            tick();
        end
        set_c(1, 0, 0, '0, '0, '0);
        drain();
        chk("t3_first", DW'(alog_at(0)), DW'(40));
        chk("t3_second", DW'(alog_at(1)), DW'(32));
        chk("t3_cmd_write", DW'((clog.size() > 1) ? clog[1] : 1'b0), DW'(1));
        chk("t3_mask", DW'((mlog.size() > 1) ? mlog[1] : 8'h00), DW'(8'hFF));
        chk("t3_wbeats", DW'(wlog.size()), DW'(BC));
        for (int k = 0; k < BC && k < wlog.size(); k++) chk($sformatf("t3_wbeat%0d", k), wlog[k], wv[k]);
        for (int k = 0; k < BC; k++) chk($sformatf("t3_ram%0d", k), mem[8'd32 + AW'(k)], wv[k]);
        chk_rd(0, 8'd40);
        for (int k = 0; k < BC; k++) ref_mem[8'd32 + AW'(k)] = merge(ref_mem[8'd32 + AW'(k)], wv[k], 8'hFF);
        clear_logs();
        set_c(1, 1, 0, 8'd32, '1, '0);
        tick();
        set_c(1, 0, 0, '0, '0, '0);
        drain();
        chk_rd(1, 8'd32);

        // Strobe while busy is ignored
        clear_logs();
        set_c(0, 1, 0, 8'd48, '1, '0);
        tick();
        chk("t4_busy_high", DW'(c0_busy), DW'(1));
        set_c(0, 1, 1, 8'd60, 8'h0F, {$urandom, $urandom});
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        drain();
        chk("t4_ncmd", DW'(alog.size()), DW'(1));
        chk("t4_addr", DW'(alog_at(0)), DW'(48));
        chk_rd(0, 8'd48);

        // Asynchronous reset mid-read
        clear_logs();
        set_c(0, 1, 0, 8'd12, '1, '0);
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        n = 0;
        while (rd_q0.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_two_beats", DW'(rd_q0.size() >= 2), DW'(1));
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", DW'(busy), '0);
        chk("t5_rst_cmd_en", DW'({br_cmd, br_cmd_en}), '0);
        chk("t5_rst_addr", DW'(br_addr), '0);
        chk("t5_rst_wdata", br_wr_data, '0);
        chk("t5_rst_mask", DW'(br_data_mask), '0);
        chk("t5_rst_valid", DW'({c1_rd_data_valid, c0_rd_data_valid}), '0);
        chk("t5_rst_rd_data", c0_rd_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        tick();
        set_c(0, 1, 0, 8'd64, '1, '0);
        set_c(1, 1, 0, 8'd0, '1, '0);
        tick();
        set_c(0, 0, 0, '0, '0, '0);
        set_c(1, 0, 0, '0, '0, '0);
        drain();
        chk("t5_prio_first", DW'(alog_at(0)), DW'(64));
        chk("t5_prio_second", DW'(alog_at(1)), DW'(0));
        chk_rd(1, 8'd0);
        chk_rd(0, 8'd64);

        // Randomized traffic: clients use disjoint halves of memory
        clear_logs();
        exp_q0.delete();
        exp_q1.delete();
        busy_rand = 1'b1;
        acc = 0;
        wleft[0] = 0;
        wleft[1] = 0;
        for (int cy = 0; cy < 3000; cy++) begin
            for (int c = 0; c < 2; c++) begin
                if (wleft[c] > 0) begin
                    set_c(c, 0, 1, '0, '0, wbuf[c][BC - wleft[c]]);
                    wleft[c]--;
                end else if (!busy[c] && $urandom_range(0, 2) == 0) begin
                    a = AW'(c * 128 + 4 * $urandom_range(0, 31));
                    m = MW'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        for (int k = 0; k < BC; k++) begin
                            wbuf[c][k] = {$urandom, $urandom};
                            ref_mem[a + AW'(k)] = merge(ref_mem[a + AW'(k)], wbuf[c][k], m);
                        end
                        set_c(c, 1, 1, a, m, wbuf[c][0]);
                        wleft[c] = BC - 1;
                    end else begin
                        for (int k = 0; k < BC; k++) begin
                            if (c == 0) exp_q0.push_back(ref_mem[a + AW'(k)]);
                            else exp_q1.push_back(ref_mem[a + AW'(k)]);
                        end
                        set_c(c, 1, 0, a, m, {$urandom, $urandom});
                    end
                    acc++;
                end else if (busy[c] && $urandom_range(0, 7) == 0) begin
                    set_c(c, 1, 1'($urandom_range(0, 1)), AW'($urandom), MW'($urandom), {$urandom, $urandom});
                end else begin
                    set_c(c, 0, 0, '0, '0, {$urandom, $urandom});
                end
            end
            tick();
        end
        set_c(0, 0, 0, '0, '0, '0);
        set_c(1, 0, 0, '0, '0, '0);
        drain();
        chk("rnd_ncmd", DW'(alog.size()), DW'(acc));
        chk("rnd_c0_count", DW'(rd_q0.size()), DW'(exp_q0.size()));
        chk("rnd_c1_count", DW'(rd_q1.size()), DW'(exp_q1.size()));
        errs = 0;
        for (int i = 0; i < rd_q0.size() && i < exp_q0.size(); i++) if (rd_q0[i] !== exp_q0[i]) errs++;
        chk("rnd_c0_data_errs", DW'(errs), '0);
        errs = 0;
        for (int i = 0; i < rd_q1.size() && i < exp_q1.size(); i++) if (rd_q1[i] !== exp_q1[i]) errs++;
        chk("rnd_c1_data_errs", DW'(errs), '0);
        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) errs++;
        chk("mem_image_errs", DW'(errs), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/burst_ram_arbiter.md
# burst_ram_arbiter

Two-client arbiter between the instruction/data caches and the single BurstRAM controller. It exposes two client ports that are protocol-identical to the BurstRAM port, so each cache connects unchanged. It buffers each client's command and write burst, serialises transactions onto BurstRAM with round-robin priority, and routes read beats back to the owning client.

## Interface
- DATA_BITWIDTH, 64, width of one burst beat
- DEPTH_BITWIDTH, 8, BurstRAM address width
- BURST_COUNT, 4, beats per transaction; power of two, ≥2
- clk  in  1  single clock for clients and RAM side
- rst  in  1  reset; asynchronous, active-high
- cN_cmd  in  1  client N (N=0,1) command: 0 read, 1 write
- cN_cmd_en  in  1  client N command strobe, one cycle
- cN_addr  in  DEPTH_BITWIDTH  client N burst address
- cN_wr_data  in  DATA_BITWIDTH  client N write beat
- cN_data_mask  in  DATA_BITWIDTH/8  client N byte mask, sampled with cmd_en
- cN_rd_data  out  DATA_BITWIDTH  read beat to client N
- cN_rd_data_valid  out  1  read beat valid for client N
- cN_busy  out  1  client N must not strobe cmd_en
- br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  widths as client side  to BurstRAM
- br_rd_data  in  DATA_BITWIDTH  from BurstRAM
- br_rd_data_valid  in  1  from BurstRAM
- br_busy  in  1  from BurstRAM

## Operation
- Per-client capture slot: cmd, addr, mask, BURST_COUNT write beats, beat counter, pending flag.
- Capture: cmd_en with cN_busy low latches cmd/addr/mask. Read: pending set at that edge. Write: beat 0 latched with cmd_en, beats 1..BURST_COUNT-1 on the following consecutive cycles; pending set on the edge latching the last beat.
- Capture proceeds independently of the other client's transaction in service.
- cN_busy rises the cycle after an accepted cmd_en. It stays high until that client's transaction reaches RELEASE and falls the following cycle.
- cmd_en while cN_busy is high is ignored; no state change.
- FSM states:
  - IDLE: if br_busy low and any pending, grant. With both pending, the grant goes to the priority holder.
  - ISSUE: one cycle. br_cmd_en=1 with slot cmd/addr/mask; br_wr_data carries beat 0 on a write. Next state is WRITE for a write, READ for a read.
  - WRITE: drive beats 1..BURST_COUNT-1 on consecutive cycles, then go to RELEASE.
  - READ: count br_rd_data_valid beats; after BURST_COUNT beats, go to RELEASE.
  - RELEASE: one cycle. Clear the owner's pending flag, give priority to the non-owner, return to IDLE.
- Read routing:
  - cN_rd_data = br_rd_data (combinational, both clients).
  - cN_rd_data_valid = br_rd_data_valid & (state==READ) & (owner==N).
  - Valid beats outside READ are dropped.
- br_* outputs come from state and slot registers, with no combinational path from client inputs. br_cmd_en is high only in ISSUE.
- Reset, including mid-transaction:
  - Pending flags and counters cleared; FSM to IDLE.
  - Priority goes to client 0.
  - All outputs 0, including cN_busy.
  - Any in-flight burst is abandoned; BurstRAM shares rst.

## Timing
- Idle arbiter, read strobed in cycle t: pending at edge t, IDLE grants in t+1, br_cmd_en high in cycle t+2.
- Write strobed in cycle t: client beats in t..t+BURST_COUNT-1. br_cmd_en with beat 0 in cycle t+BURST_COUNT+1; remaining beats in the consecutive following cycles.
- Read data: zero added latency; beats pass through in the same cycle BurstRAM presents them.
- Back-to-back transactions: minimum one RELEASE cycle plus one IDLE cycle between the last beat of one transaction and the next br_cmd_en.
- br_busy high in IDLE blocks granting. br_busy is not checked in other states.

## Test plan
- Single read, client 0, addr 4, RAM loaded from RAM.mem -> br_cmd_en in the 2nd cycle after the strobe with br_addr=4. Four beats equal to RAM words 4..7 appear only on c0_rd_data_valid. c0_busy falls two cycles after the 4th beat; c1_rd_data_valid stays 0 throughout.
- Simultaneous reads after reset, c0 addr 8 and c1 addr 16 -> c0 is served first, then c1. In a second simultaneous pair, c1 is served first (round-robin).
- c1 writes 4 beats 0x1111…1 to 0x4444…4 to addr 32 with mask 0xFF while a c0 read is in progress -> the write is buffered. BurstRAM receives exactly those beats in order after the c0 read completes. A following c1 read of addr 32 returns the same four values.
- c0 strobes cmd_en while c0_busy is high -> no extra br_cmd_en; pending state unchanged.
- rst asserted after the 2nd read beat -> all outputs 0 immediately (asynchronous). After release, a c1 read at addr 0 completes normally, with priority back at client 0.
